// File: rtl/pcie_cpl_tx_if.sv
// Signal bundle for pcie_cpl_tx: completer ID, job request, payload stream,
// and the VC0 TX handshake/credit signals. The DUT uses the slave modport;
// the job source / core side uses master. req_ur exists only with CPL_TX_UR_EN.
interface pcie_cpl_tx_if;
  logic [7:0]  bus_num;
  logic [4:0]  dev_num;
  logic [2:0]  func_num;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_tag;
  logic [15:0] req_rid;
  logic [6:0]  req_lower_addr;
  logic [9:0]  req_len_dw;
`ifdef CPL_TX_UR_EN
  logic        req_ur;
`endif
  logic        dat_valid;
  logic        dat_ready;
  logic [63:0] dat_data;
  logic        tx_req_vc0;
  logic        tx_rdy_vc0;
  logic        tx_st_vc0;
  logic        tx_end_vc0;
  logic        tx_dwen_vc0;
  logic        tx_nlfy_vc0;
  logic [63:0] tx_data_vc0;
  logic [8:0]  tx_ca_cplh_vc0;
  logic [12:0] tx_ca_cpld_vc0;
  logic        tx_ca_cpl_recheck_vc0;
  logic        busy;
  logic        cpl_done;

  modport master (
`ifdef CPL_TX_UR_EN
    output req_ur,
`endif
    output bus_num, dev_num, func_num,
    output req_valid, req_tag, req_rid, req_lower_addr, req_len_dw,
    output dat_valid, dat_data,
    output tx_rdy_vc0, tx_ca_cplh_vc0, tx_ca_cpld_vc0, tx_ca_cpl_recheck_vc0,
    input  req_ready, dat_ready,
    input  tx_req_vc0, tx_st_vc0, tx_end_vc0, tx_dwen_vc0, tx_nlfy_vc0, tx_data_vc0,
    input  busy, cpl_done
  );

  modport slave (
`ifdef CPL_TX_UR_EN
    input  req_ur,
`endif
    input  bus_num, dev_num, func_num,
    input  req_valid, req_tag, req_rid, req_lower_addr, req_len_dw,
    input  dat_valid, dat_data,
    input  tx_rdy_vc0, tx_ca_cplh_vc0, tx_ca_cpld_vc0, tx_ca_cpl_recheck_vc0,
    output req_ready, dat_ready,
    output tx_req_vc0, tx_st_vc0, tx_end_vc0, tx_dwen_vc0, tx_nlfy_vc0, tx_data_vc0,
    output busy, cpl_done
  );
endinterface

// File: rtl/pcie_cpl_tx.sv
// pcie_cpl_tx: buffers one memory-read completion payload, waits for
// completion credits, then emits a 3DW-header CplD TLP on the VC0 TX port.
// Optional CPL_TX_UR_EN adds req_ur: such jobs skip the payload and go out
// as a data-less Cpl with UR status.
module pcie_cpl_tx #(
  parameter int MAX_LEN_DW = 32
) (
  input  logic         sys_clk_125,
  input  logic         rst,
  pcie_cpl_tx_if.slave cif
);
  localparam int         DEPTH   = MAX_LEN_DW / 2;
  localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [9:0] MAX_LEN = 10'(MAX_LEN_DW);

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_CREDIT, S_REQ, S_SEND} state_t;

  state_t      state_q, state_d;
  logic [7:0]  tag_q, tag_d;
  logic [15:0] rid_q, rid_d;
  logic [6:0]  laddr_q, laddr_d;
  logic [9:0]  len_q, len_d;
  logic        ur_q, ur_d;
  logic [9:0]  wr_cnt_q, wr_cnt_d;
  logic [9:0]  bcnt_q, bcnt_d;
  logic [31:0] lo_q, lo_d;
  logic        tx_req_q, tx_req_d;
  logic        tx_st_q, tx_st_d;
  logic        tx_end_q, tx_end_d;
  logic        tx_dwen_q, tx_dwen_d;
  logic        done_q, done_d;
  logic [63:0] tx_data_q, tx_data_d;
  logic        mem_we;

  logic [63:0] mem [DEPTH];

  logic [10:0] len_p1;
  logic [11:0] len_p3;
  logic [9:0]  nfill, last_idx, len_in;
  logic [11:0] cpld_need;
  logic        cplh_ok, cpld_ok, ur_in;
  logic [31:0] dw0, dw1, dw2, rd_hi;
  logic [63:0] rd_beat;

  // Job-derived quantities, header words and the buffer read for the next beat
  always_comb begin
`ifdef CPL_TX_UR_EN
    ur_in     = cif.req_ur;
`else
    ur_in     = 1'b0;
`endif
    len_in    = (cif.req_len_dw == 10'd0 || cif.req_len_dw > MAX_LEN) ? MAX_LEN : cif.req_len_dw;
    len_p1    = {1'b0, len_q} + 11'd1;
    len_p3    = {2'b00, len_q} + 12'd3;
    nfill     = len_p1[10:1];
    cpld_need = {2'b00, len_p3[11:2]};
    // beats are numbered from 0; a CplD has len/2+2 beats (rounded down)
    last_idx  = ur_q ? 10'd1 : ({1'b0, len_q[9:1]} + 10'd1);
    cplh_ok   = cif.tx_ca_cplh_vc0[8] | (cif.tx_ca_cplh_vc0[7:0] != 8'd0);
    cpld_ok   = ur_q | cif.tx_ca_cpld_vc0[12] | (cif.tx_ca_cpld_vc0[11:0] >= cpld_need);
    dw0       = ur_q ? {3'b000, 5'b01010, 24'd0} : {3'b010, 5'b01010, 14'd0, len_q};
    dw1       = {cif.bus_num, cif.dev_num, cif.func_num, (ur_q ? 3'b001 : 3'b000), 1'b0, len_q, 2'b00};
    dw2       = {rid_q, tag_q, 1'b0, laddr_q};
    // header is 3 DWs, so every payload beat straddles two buffer words:
    // high half comes from word bcnt, low half was saved from word bcnt-1
    rd_beat   = mem[bcnt_q[AW-1:0]];
    rd_hi     = (ur_q || bcnt_q >= nfill) ? 32'd0 : rd_beat[63:32];
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    tag_d     = tag_q;
    rid_d     = rid_q;
    laddr_d   = laddr_q;
    len_d     = len_q;
    ur_d      = ur_q;
    wr_cnt_d  = wr_cnt_q;
    bcnt_d    = bcnt_q;
    lo_d      = lo_q;
    tx_req_d  = tx_req_q;
    tx_st_d   = 1'b0;
    tx_end_d  = 1'b0;
    tx_dwen_d = 1'b0;
    tx_data_d = 64'd0;
    done_d    = 1'b0;
    mem_we    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cif.req_valid) begin
          tag_d    = cif.req_tag;
          rid_d    = cif.req_rid;
          laddr_d  = cif.req_lower_addr;
          len_d    = len_in;
          ur_d     = ur_in;
          wr_cnt_d = 10'd0;
          state_d  = ur_in ? S_CREDIT : S_FILL;
        end
      end
      S_FILL: begin
        if (cif.dat_valid) begin
          mem_we = 1'b1;
          if (wr_cnt_q + 10'd1 == nfill) begin
            wr_cnt_d = 10'd0;
            state_d  = S_CREDIT;
          end else begin
            wr_cnt_d = wr_cnt_q + 10'd1;
          end
        end
      end
      S_CREDIT: begin
        if (cplh_ok && cpld_ok) begin
          tx_req_d = 1'b1;
          state_d  = S_REQ;
        end
      end
      S_REQ: begin
        if (cif.tx_rdy_vc0) begin
          tx_req_d  = 1'b0;
          bcnt_d    = 10'd0;
          tx_st_d   = 1'b1;
          tx_data_d = {dw0, dw1};
          state_d   = S_SEND;
        end else if (cif.tx_ca_cpl_recheck_vc0) begin
          tx_req_d = 1'b0;
          state_d  = S_CREDIT;
        end
      end
      S_SEND: begin
        if (bcnt_q == last_idx) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          bcnt_d    = bcnt_q + 10'd1;
          tx_data_d = (bcnt_q == 10'd0) ? {dw2, rd_hi} : {lo_q, rd_hi};
          lo_d      = rd_beat[31:0];
          tx_end_d  = (bcnt_d == last_idx);
          tx_dwen_d = tx_end_d & (ur_q | ~len_q[0]);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge sys_clk_125 or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      tag_q     <= '0;
      rid_q     <= '0;
      laddr_q   <= '0;
      len_q     <= '0;
      ur_q      <= 1'b0;
      wr_cnt_q  <= '0;
      bcnt_q    <= '0;
      lo_q      <= '0;
      tx_req_q  <= 1'b0;
      tx_st_q   <= 1'b0;
      tx_end_q  <= 1'b0;
      tx_dwen_q <= 1'b0;
      tx_data_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tag_q     <= tag_d;
      rid_q     <= rid_d;
      laddr_q   <= laddr_d;
      len_q     <= len_d;
      ur_q      <= ur_d;
      wr_cnt_q  <= wr_cnt_d;
      bcnt_q    <= bcnt_d;
      lo_q      <= lo_d;
      tx_req_q  <= tx_req_d;
      tx_st_q   <= tx_st_d;
      tx_end_q  <= tx_end_d;
      tx_dwen_q <= tx_dwen_d;
      tx_data_q <= tx_data_d;
      done_q    <= done_d;
    end
  end

  // Payload buffer write; contents need no reset
  always_ff @(posedge sys_clk_125) begin
    if (mem_we) mem[wr_cnt_q[AW-1:0]] <= cif.dat_data;
  end

  assign cif.req_ready   = (state_q == S_IDLE);
  assign cif.dat_ready   = (state_q == S_FILL);
  assign cif.busy        = (state_q != S_IDLE);
  assign cif.tx_req_vc0  = tx_req_q;
  assign cif.tx_st_vc0   = tx_st_q;
  assign cif.tx_end_vc0  = tx_end_q;
  assign cif.tx_dwen_vc0 = tx_dwen_q;
  assign cif.tx_nlfy_vc0 = 1'b0;
  assign cif.tx_data_vc0 = tx_data_q;
  assign cif.cpl_done    = done_q;
endmodule

// File: tb/tb_pcie_cpl_tx.sv
// Bench for pcie_cpl_tx: directed jobs, a TLP model built from the header and
// payload rules, and one compare process checking the TX port every cycle.
module tb_pcie_cpl_tx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #4 clk = ~clk;

  pcie_cpl_tx_if cif();
  pcie_cpl_tx #(.MAX_LEN_DW(32)) dut (.sys_clk_125(clk), .rst(rst), .cif(cif));

  typedef struct packed {
    logic [9:0]  len;
    logic [7:0]  tag;
    logic [15:0] rid;
    logic [6:0]  la;
    logic        ur;
  } job_t;

  int          n_chk = 0;
  int          n_pass = 0;
  job_t        job;
  logic [31:0] pay [0:31];
  logic [63:0] exp_beats [$];
  bit          exp_dwen;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // TLP as a flat DW list (3 header DWs + payload), zero-padded to whole beats
  function automatic void build_exp();
    logic [31:0] dw [$];
    int nd;
    exp_beats.delete();
    dw.push_back(job.ur ? 32'h0A00_0000 : {8'h4A, 14'd0, job.len});
    dw.push_back({cif.bus_num, cif.dev_num, cif.func_num, (job.ur ? 3'b001 : 3'b000), 1'b0, job.len, 2'b00});
    dw.push_back({job.rid, job.tag, 1'b0, job.la});
    nd = job.ur ? 0 : int'(job.len);
    for (int i = 0; i < nd; i++) dw.push_back(pay[i]);
    exp_dwen = (dw.size() % 2 == 1);
    if (exp_dwen) dw.push_back(32'd0);
    for (int i = 0; i < dw.size(); i += 2) exp_beats.push_back({dw[i], dw[i+1]});
  endfunction

  // Compare process: grant seen at one negedge -> beat0 at the next negedge,
  // then every expected beat on consecutive cycles, then a cpl_done pulse.
  int beat_no = -1;
  bit granted = 1'b0;
  bit done_exp = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_ctrl", {cif.tx_req_vc0, cif.tx_st_vc0, cif.tx_end_vc0, cif.tx_dwen_vc0,
                       cif.cpl_done, cif.busy, cif.dat_ready}, 64'd0);
      chk("rst_data", cif.tx_data_vc0, 64'd0);
      chk("rst_req_ready", cif.req_ready, 1);
      beat_no  = -1;
      granted  = 1'b0;
      done_exp = 1'b0;
    end else begin
      chk("cpl_done", cif.cpl_done, done_exp);
      done_exp = 1'b0;
      if (granted) begin
        beat_no = 0;
        granted = 1'b0;
      end
      if (beat_no >= 0) begin
        chk($sformatf("beat%0d_data", beat_no), cif.tx_data_vc0, exp_beats[beat_no]);
        chk($sformatf("beat%0d_st", beat_no), cif.tx_st_vc0, beat_no == 0);
        chk($sformatf("beat%0d_end", beat_no), cif.tx_end_vc0, beat_no == exp_beats.size() - 1);
        chk($sformatf("beat%0d_dwen", beat_no), cif.tx_dwen_vc0,
            (beat_no == exp_beats.size() - 1) && exp_dwen);
        if (beat_no == exp_beats.size() - 1) begin
          beat_no  = -1;
          done_exp = 1'b1;
        end else begin
          beat_no++;
        end
      end else begin
        chk("idle_data", cif.tx_data_vc0, 64'd0);
        chk("idle_st_end", {cif.tx_st_vc0, cif.tx_end_vc0}, 64'd0);
      end
      chk("nlfy", cif.tx_nlfy_vc0, 0);
      if (cif.tx_req_vc0 && cif.tx_rdy_vc0 && beat_no < 0) granted = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [9:0] len, input logic [7:0] tag, input logic [15:0] rid,
                           input logic [6:0] la, input bit ur);
    int n;
    job = '{len: len, tag: tag, rid: rid, la: la, ur: ur};
    build_exp();
    cif.req_valid      = 1'b1;
    cif.req_len_dw     = len;
    cif.req_tag        = tag;
    cif.req_rid        = rid;
    cif.req_lower_addr = la;
`ifdef CPL_TX_UR_EN
    cif.req_ur         = ur;
`endif
    n = 0;
    while (!cif.req_ready && n < 100) begin tick(); n++; end
    chk("req_ready_wait", cif.req_ready, 1);
    tick();
    cif.req_valid = 1'b0;
  endtask

  task automatic feed(input int len, input bit gaps);
    int n;
    for (int b = 0; b < (len + 1) / 2; b++) begin
      cif.dat_valid = 1'b1;
      cif.dat_data  = {pay[2*b], (2*b + 1 < len) ? pay[2*b+1] : 32'hFFFF_FFFF};
      n = 0;
      while (!cif.dat_ready && n < 100) begin tick(); n++; end
      chk("dat_ready_wait", cif.dat_ready, 1);
      tick();
      cif.dat_valid = 1'b0;
      if (gaps) tick();
    end
  endtask

  task automatic wait_req(input string nm);
    int n;
    n = 0;
    while (!cif.tx_req_vc0 && n < 100) begin tick(); n++; end
    chk(nm, cif.tx_req_vc0, 1);
  endtask

  task automatic grant(input int dly);
    int n;
    wait_req("tx_req_wait");
    for (int i = 0; i < dly; i++) begin
      tick();
      chk("tx_req_held", cif.tx_req_vc0, 1);
    end
    cif.tx_rdy_vc0 = 1'b1;
    n = 0;
    while (!cif.cpl_done && n < 100) begin tick(); n++; end
    chk("cpl_done_wait", cif.cpl_done, 1);
    cif.tx_rdy_vc0 = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    cif.bus_num = 8'h01; cif.dev_num = 5'd0; cif.func_num = 3'd0;
    cif.req_valid = 1'b0; cif.req_tag = '0; cif.req_rid = '0;
    cif.req_lower_addr = '0; cif.req_len_dw = '0;
`ifdef CPL_TX_UR_EN
    cif.req_ur = 1'b0;
`endif
    cif.dat_valid = 1'b0; cif.dat_data = '0;
    cif.tx_rdy_vc0 = 1'b0; cif.tx_ca_cpl_recheck_vc0 = 1'b0;
    cif.tx_ca_cplh_vc0 = 9'h100; cif.tx_ca_cpld_vc0 = 13'h1000;
    for (int i = 0; i < 32; i++) pay[i] = 32'hC500_0000 + 32'(i) * 32'h0001_0101;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("post_rst_req_ready", cif.req_ready, 1);
    chk("post_rst_busy", cif.busy, 0);

    // 1: single-DW completion
    pay[0] = 32'hDEAD_BEEF;
    start_job(10'd1, 8'h12, 16'h0100, 7'h04, 1'b0);
    chk("t1_busy", cif.busy, 1);
    chk("t1_model_b0", exp_beats[0], 64'h4A000001_01000004);
    chk("t1_model_b1", exp_beats[1], 64'h01001204_DEADBEEF);
    feed(1, 1'b0);
    chk("t1_dat_ready_off", cif.dat_ready, 0);
    grant(0);

    // 2: even length, end beat half-filled; req_valid while busy is ignored
    pay[0] = 32'hAAAA_0001; pay[1] = 32'hBBBB_0002;
    start_job(10'd2, 8'h34, 16'h0203, 7'h08, 1'b0);
    chk("t2_model_nbeats", exp_beats.size(), 3);
    chk("t2_model_b2", exp_beats[2], 64'hBBBB0002_00000000);
    cif.req_valid = 1'b1; cif.req_tag = 8'hEE; cif.req_len_dw = 10'd5;
    chk("t2_req_ready_busy", cif.req_ready, 0);
    feed(2, 1'b0);
    cif.req_valid = 1'b0;
    grant(1);

    // 3: finite CplD credits block the request until raised
    for (int i = 0; i < 8; i++) pay[i] = 32'h3000_0000 + 32'(i);
    cif.tx_ca_cpld_vc0 = 13'd1;
    start_job(10'd8, 8'h56, 16'h0405, 7'h10, 1'b0);
    feed(8, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("t3_no_req", cif.tx_req_vc0, 0);
      tick();
    end
    cif.tx_ca_cpld_vc0 = 13'd2;
    tick();
    chk("t3_req_after_credit", cif.tx_req_vc0, 1);
    grant(2);
    cif.tx_ca_cpld_vc0 = 13'h1000;

    // 4: recheck with no CplH credit withdraws the request
    for (int i = 0; i < 4; i++) pay[i] = 32'h4400_0000 + 32'(i);
    start_job(10'd4, 8'h78, 16'h0607, 7'h20, 1'b0);
    feed(4, 1'b0);
    wait_req("t4_req_first");
    cif.tx_ca_cplh_vc0 = 9'd0;
    cif.tx_ca_cpl_recheck_vc0 = 1'b1;
    tick();
    cif.tx_ca_cpl_recheck_vc0 = 1'b0;
    chk("t4_req_dropped", cif.tx_req_vc0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_req_low", cif.tx_req_vc0, 0);
    end
    cif.tx_ca_cplh_vc0 = 9'd1;
    tick();
    chk("t4_req_again", cif.tx_req_vc0, 1);
    grant(1);
    cif.tx_ca_cplh_vc0 = 9'h100;

    // 5: full-buffer length with payload gaps and delayed grant
    for (int i = 0; i < 32; i++) pay[i] = 32'h5A00_0000 + 32'(i) * 32'h0001_0003;
    cif.dev_num = 5'd3; cif.func_num = 3'd2;
    start_job(10'd32, 8'h9A, 16'h0809, 7'h7C, 1'b0);
    chk("t5_model_nbeats", exp_beats.size(), 18);
    feed(32, 1'b1);
    grant(5);

    // 6: reset asserted while beat 3 is on the bus
    start_job(10'd32, 8'hBC, 16'h0A0B, 7'h40, 1'b0);
    feed(32, 1'b0);
    wait_req("t6_req");
    cif.tx_rdy_vc0 = 1'b1;
    n = 0;
    while (!cif.tx_st_vc0 && n < 20) begin tick(); n++; end
    chk("t6_st_seen", cif.tx_st_vc0, 1);
    repeat (3) tick();
    rst = 1'b1;
    #1;
    chk("t6_rst_ctrl", {cif.tx_req_vc0, cif.tx_st_vc0, cif.tx_end_vc0, cif.tx_dwen_vc0,
                        cif.cpl_done, cif.busy, cif.dat_ready}, 64'd0);
    chk("t6_rst_data", cif.tx_data_vc0, 64'd0);
    cif.tx_rdy_vc0 = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    chk("t6_req_ready", cif.req_ready, 1);

    // recovery: odd length after reset
    for (int i = 0; i < 3; i++) pay[i] = 32'h6600_0000 + 32'(i);
    start_job(10'd3, 8'hDE, 16'h0C0D, 7'h0C, 1'b0);
    feed(3, 1'b0);
    grant(0);

`ifdef CPL_TX_UR_EN
    // UR completion: no payload, CplD credits not consulted
    cif.dev_num = 5'd0; cif.func_num = 3'd0;
    cif.tx_ca_cpld_vc0 = 13'd0;
    start_job(10'd1, 8'h20, 16'h0100, 7'h00, 1'b1);
    chk("ur_model_b0", exp_beats[0], 64'h0A000000_01002004);
    grant(0);
    cif.req_ur = 1'b0;
    cif.tx_ca_cpld_vc0 = 13'h1000;
`endif

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
